// File: rtl/tt_exerciser_pkg.sv
// Shared types and the reference truth function for the logic-tile exerciser.
package tt_exerciser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ANDOR = 2'b00;
  localparam logic [1:0] MODE_AND3  = 2'b01;
  localparam logic [1:0] MODE_OR3   = 2'b10;
  localparam logic [1:0] MODE_XOR3  = 2'b11;

  localparam logic [3:0] FAIL_SAT = 4'd8;

  // Expected tile response for vector {c,b,a}, a = bit 0.
  function automatic logic expected(input logic [1:0] mode, input logic [2:0] vec);
    logic result;
    case (mode)
      MODE_ANDOR: result = (vec[0] | vec[1]) & vec[2];
      MODE_AND3:  result = &vec;
      MODE_OR3:   result = |vec;
      default:    result = ^vec;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tt_logic_exerciser_if.sv
// Pin bundle of the TinyTapeout user_module slot.
interface tt_logic_exerciser_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (input io_in, output io_out);
  modport slave  (output io_in, input io_out);
endinterface

// File: rtl/tt_sync_ff.sv
// Multi-stage synchronizer for an asynchronous input pin, clears to 0 on reset.
module tt_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/tt_logic_exerciser.sv
// Walks {c,b,a} through all eight vectors, samples the tile response after a
// settle window and reports busy/done/pass and a saturating mismatch count.
module tt_logic_exerciser
  import tt_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  tt_logic_exerciser_if.master  pins
);

  localparam int              CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic             start_sync;
  logic             resp_sync;
  logic             start_rise;
  logic             start_prev_reg;
  state_t           state_reg, state_next;
  logic [2:0]       vec_reg, vec_next;
  logic [CNT_W-1:0] settle_reg, settle_next;
  logic [3:0]       fail_reg, fail_next;
  logic [1:0]       mode_reg, mode_next;
  logic [7:0]       out_reg, out_next;
  logic             unused_pins;

  tt_sync_ff #(.STAGES(SYNC_STAGES)) u_start_sync (
    .clk (clk),
    .rst (rst),
    .d   (pins.io_in[2]),
    .q   (start_sync)
  );

  tt_sync_ff #(.STAGES(SYNC_STAGES)) u_resp_sync (
    .clk (clk),
    .rst (rst),
    .d   (pins.io_in[3]),
    .q   (resp_sync)
  );

  // clk/rst arrive on dedicated ports; their pin copies and io_in[7:6] are ignored.
  assign unused_pins = &{1'b0, pins.io_in[7:6], pins.io_in[1:0]};
  assign start_rise  = start_sync & ~start_prev_reg;

  always_comb begin
    state_next  = state_reg;
    vec_next    = vec_reg;
    settle_next = settle_reg;
    fail_next   = fail_reg;
    mode_next   = mode_reg;
    out_next    = '0;

    case (state_reg)
      IDLE, DONE: begin
        if (start_rise) begin
          state_next  = DRIVE;
          vec_next    = '0;
          settle_next = '0;
          fail_next   = '0;
          mode_next   = pins.io_in[5:4];
        end
      end
      DRIVE: begin
        if (settle_reg == SETTLE_LAST) begin
          state_next = SAMPLE;
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end
      SAMPLE: begin
        if ((resp_sync != expected(mode_reg, vec_reg)) && (fail_reg != FAIL_SAT)) begin
          fail_next = fail_reg + 4'd1;
        end
        if (vec_reg == 3'd7) begin
          state_next = DONE;
        end else begin
          vec_next    = vec_reg + 3'd1;
          settle_next = '0;
          state_next  = DRIVE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from next-state values so io_out is a plain register.
    case (state_next)
      DRIVE, SAMPLE: begin
        out_next[2:0] = vec_next;
        out_next[3]   = 1'b1;
        out_next[7:6] = (fail_next > 4'd3) ? 2'd3 : fail_next[1:0];
      end
      DONE: begin
        out_next[4]   = 1'b1;
        out_next[5]   = (fail_next == 4'd0);
        out_next[7:6] = (fail_next > 4'd3) ? 2'd3 : fail_next[1:0];
      end
      default: out_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      vec_reg        <= '0;
      settle_reg     <= '0;
      fail_reg       <= '0;
      mode_reg       <= '0;
      start_prev_reg <= 1'b0;
      out_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      vec_reg        <= vec_next;
      settle_reg     <= settle_next;
      fail_reg       <= fail_next;
      mode_reg       <= mode_next;
      start_prev_reg <= start_sync;
      out_reg        <= out_next;
    end
  end

  assign pins.io_out = out_reg;

endmodule

// File: tb/tb_tt_logic_exerciser.sv
// Self-checking bench: a truth-table tile model answers the exerciser, and each
// run is checked against mismatch counts derived from the mode definitions.
module tb_tt_logic_exerciser;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] tile_tt;
  logic       resp;
  int         tests_run;
  int         tests_failed;
  int         run_id;

  tt_logic_exerciser_if pins ();

  assign pins.io_in = {2'b00, mode, resp, start, rst, clk};

  // Tile under test: combinational lookup of its truth table.
  always_comb resp = tile_tt[pins.io_out[2:0]];

  tt_logic_exerciser #(
    .SETTLE_CYCLES (4),
    .SYNC_STAGES   (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pins (pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_fn(input logic [1:0] m, input int v);
    int a;
    int b;
    int c;
    int ones;
    a    = v % 2;
    b    = (v / 2) % 2;
    c    = (v / 4) % 2;
    ones = a + b + c;
    case (m)
      2'd0:    return (c == 1) && (a + b >= 1);
      2'd1:    return ones == 3;
      2'd2:    return ones >= 1;
      default: return (ones % 2) == 1;
    endcase
  endfunction

  function automatic int ref_mismatches(input logic [1:0] m, input logic [7:0] tt);
    int n;
    n = 0;
    for (int v = 0; v < 8; v++) begin
      if (tt[v] != ref_fn(m, v)) n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] good_tt(input logic [1:0] m);
    logic [7:0] t;
    for (int v = 0; v < 8; v++) t[v] = ref_fn(m, v);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [1:0] m, input logic [7:0] tt, input bit hold);
    int  cnt;
    int  len;
    bit  seen;
    cnt = ref_mismatches(m, tt);
    run_id++;
    mode    = m;
    tile_tt = tt;
    @(negedge clk);
    start = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      seen = (pins.io_out[3] === 1'b1);
    end
    start = 1'b0;
    check($sformatf("run%0d_busy_rise", run_id), 32'(seen), 32'd1);
    check($sformatf("run%0d_done_clear", run_id), 32'(pins.io_out[4]), 32'd0);
    len = 0;
    while (pins.io_out[3] === 1'b1 && len < 100) begin
      check($sformatf("run%0d_vec%0d", run_id, len), 32'(pins.io_out[2:0]), 32'(len / 5));
      if (len == 3) mode = ~m;
      if (hold && len == 12) start = 1'b1;
      len++;
      @(negedge clk);
    end
    check($sformatf("run%0d_busy_len", run_id), 32'(len), 32'd40);
    check($sformatf("run%0d_done", run_id), 32'(pins.io_out[4]), 32'd1);
    check($sformatf("run%0d_pass", run_id), 32'(pins.io_out[5]), 32'(cnt == 0));
    check($sformatf("run%0d_fails", run_id), 32'(pins.io_out[7:6]), 32'(cnt > 3 ? 3 : cnt));
    check($sformatf("run%0d_vec_idle", run_id), 32'(pins.io_out[2:0]), 32'd0);
    repeat (3) @(negedge clk);
    check($sformatf("run%0d_done_hold", run_id), 32'(pins.io_out[7:3]),
          {27'd0, 2'(cnt > 3 ? 3 : cnt), (cnt == 0), 1'b1, 1'b0});
    if (hold) begin
      repeat (8) @(negedge clk);
      check($sformatf("run%0d_no_retrigger", run_id), 32'(pins.io_out[3]), 32'd0);
      start = 1'b0;
      repeat (3) @(negedge clk);
    end
    $display("[TB] run %0d mode %0d tt %02h mismatches %0d busy_len %0d io_out %02h",
             run_id, m, tt, cnt, len, pins.io_out);
  endtask

  initial begin
    bit found;
    tests_run    = 0;
    tests_failed = 0;
    run_id       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    mode         = 2'd0;
    tile_tt      = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_io_out", 32'(pins.io_out), 32'h00);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_io_out", 32'(pins.io_out), 32'h00);

    do_run(2'd0, good_tt(2'd0), 1'b0);
    do_run(2'd0, 8'h00, 1'b0);
    do_run(2'd1, 8'h00, 1'b0);
    do_run(2'd3, 8'hFF, 1'b0);
    do_run(2'd0, good_tt(2'd0), 1'b1);
    do_run(2'd2, good_tt(2'd2), 1'b0);

    // Abort mid-run: reset lands between clock edges while vec 3 is driven.
    mode    = 2'd0;
    tile_tt = good_tt(2'd0);
    @(negedge clk);
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      found = (pins.io_out[3] === 1'b1) && (pins.io_out[2:0] === 3'd3);
    end
    start = 1'b0;
    check("abort_reach_vec3", 32'(found), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("abort_async_clear", 32'(pins.io_out), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("abort_stay_idle%0d", i), 32'(pins.io_out), 32'h00);
    end
    $display("[TB] abort run: reset during vec 3, io_out %02h after release", pins.io_out);

    for (int r = 0; r < 6; r++) begin
      do_run(2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
